fill_rect_stream_engine: RTL and testbench

FILL_RECT_STREAM_ENGINE -- requirements
Module: fill_rect_stream_engine

---
 rtl/fill_rect_stream_engine.sv | 222 ++++++++++++++++++++++
 tb/tb_fill_rect_stream_engine.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fill_rect_stream_engine.sv
// fill_rect_stream_engine: collects a 9-byte fill command and streams the
// rectangle to the arbiter as 32-bit word writes with per-lane byte enables.
// Optional clipping to the screen is enabled by defining FILL_RECT_CLIP_EN.
module fill_rect_stream_engine #(
  parameter int ADDR_WIDTH   = 16,
  parameter int LINE_PIXELS  = 256,
  parameter int SCREEN_LINES = 192,
  parameter int FB_BASE      = 0
) (
  input  logic                  clk,
  input  logic                  rst_,
  input  logic [7:0]            cmd_in_data,
  input  logic                  cmd_in_rts,
  output logic                  cmd_out_rtr,
  output logic [31:0]           arb_out_data,
  output logic [ADDR_WIDTH-1:0] arb_out_addr,
  output logic [3:0]            arb_out_wben,
  output logic                  arb_out_rts,
  input  logic                  arb_in_rtr,
  output logic                  arb_out_op,
  output logic                  busy,
  output logic                  rect_done
);

  localparam int ROW_WORDS = LINE_PIXELS / 4;

  typedef enum logic [2:0] {COLLECT, SETUP, ROW, NEXT_ROW, DONE} state_t;

  state_t                state_q, state_d;
  logic [3:0]            byte_cnt_q, byte_cnt_d;
  logic [71:0]           cmd_q, cmd_d;
  logic                  rtr_q, rtr_d;
  logic                  rts_q, rts_d;
  logic [31:0]           data_q, data_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [3:0]            wben_q, wben_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [ADDR_WIDTH-1:0] row_addr_q, row_addr_d;
  logic [16:0]           word_idx_q, word_idx_d;
  logic [16:0]           n_words_q, n_words_d;
  logic [15:0]           rows_left_q, rows_left_d;
  logic [1:0]            lane_first_q, lane_first_d;
  logic [1:0]            lane_last_q, lane_last_d;

  logic [15:0] x_c, y_c, w_c, h_c;
  logic [63:0] pix_c;
  logic [15:0] w_eff, h_eff;
  logic        empty_c;
  logic [17:0] span_c;
  logic [16:0] n_words_c;
  logic [1:0]  lane_last_c;

  assign x_c = cmd_q[15:0];
  assign y_c = cmd_q[31:16];
  assign w_c = cmd_q[47:32];
  assign h_c = cmd_q[63:48];

  assign cmd_out_rtr  = rtr_q;
  assign arb_out_rts  = rts_q;
  assign arb_out_data = data_q;
  assign arb_out_addr = addr_q;
  assign arb_out_wben = wben_q;
  assign arb_out_op   = 1'b1;
  assign busy         = busy_q;
  assign rect_done    = done_q;

  // Byte enables for word idx of a row: trim leading lanes on the first word
  // and trailing lanes on the last word.
  function automatic logic [3:0] lane_mask(input logic [16:0] idx, input logic [16:0] n,
                                           input logic [1:0] first, input logic [1:0] last);
    logic [3:0] m;
    m = 4'hF;
    if (idx == 17'd0) m = m & (4'hF << first);
    if (idx == n - 17'd1) m = m & (4'hF >> (2'd3 - last));
    return m;
  endfunction

  // Rectangle geometry: start pixel, effective size and words per row.
  always_comb begin
    pix_c = 64'(y_c) * 64'(LINE_PIXELS) + 64'(x_c);
    w_eff = w_c;
    h_eff = h_c;
`ifdef FILL_RECT_CLIP_EN
    empty_c = (32'(x_c) >= LINE_PIXELS) || (32'(y_c) >= SCREEN_LINES);
    if (!empty_c && (32'(w_c) > LINE_PIXELS - 32'(x_c))) w_eff = 16'(LINE_PIXELS - 32'(x_c));
    if (!empty_c && (32'(h_c) > SCREEN_LINES - 32'(y_c))) h_eff = 16'(SCREEN_LINES - 32'(y_c));
`else
    empty_c = 1'b0;
`endif
    empty_c     = empty_c || (w_eff == 16'd0) || (h_eff == 16'd0);
    span_c      = 18'(pix_c[1:0]) + 18'(w_eff) - 18'd1;
    n_words_c   = 17'(span_c >> 2) + 17'd1;
    lane_last_c = span_c[1:0];
  end

  // Next-state and next-output logic for the command/rectangle sequencer.
  always_comb begin
    state_d      = state_q;
    byte_cnt_d   = byte_cnt_q;
    cmd_d        = cmd_q;
    rtr_d        = rtr_q;
    rts_d        = rts_q;
    data_d       = data_q;
    addr_d       = addr_q;
    wben_d       = wben_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    row_addr_d   = row_addr_q;
    word_idx_d   = word_idx_q;
    n_words_d    = n_words_q;
    rows_left_d  = rows_left_q;
    lane_first_d = lane_first_q;
    lane_last_d  = lane_last_q;
    case (state_q)
      COLLECT: begin
        rtr_d = 1'b1;
        if (cmd_in_rts && rtr_q) begin
          cmd_d  = {cmd_in_data, cmd_q[71:8]};
          busy_d = 1'b1;
          if (byte_cnt_q == 4'd8) begin
            byte_cnt_d = 4'd0;
            rtr_d      = 1'b0;
            state_d    = SETUP;
          end else begin
            byte_cnt_d = byte_cnt_q + 4'd1;
          end
        end
      end
      SETUP: begin
        row_addr_d   = ADDR_WIDTH'(pix_c >> 2) + ADDR_WIDTH'(FB_BASE);
        lane_first_d = pix_c[1:0];
        lane_last_d  = lane_last_c;
        n_words_d    = n_words_c;
        rows_left_d  = h_eff;
        word_idx_d   = 17'd0;
        data_d       = {4{cmd_q[71:64]}};
        if (empty_c) begin
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          rts_d   = 1'b1;
          addr_d  = row_addr_d;
          wben_d  = lane_mask(17'd0, n_words_c, pix_c[1:0], lane_last_c);
          state_d = ROW;
        end
      end
      ROW: begin
        if (rts_q && arb_in_rtr) begin
          if (word_idx_q == n_words_q - 17'd1) begin
            rts_d = 1'b0;
            if (rows_left_q == 16'd1) begin
              done_d  = 1'b1;
              state_d = DONE;
            end else begin
              rows_left_d = rows_left_q - 16'd1;
              row_addr_d  = row_addr_q + ADDR_WIDTH'(ROW_WORDS);
              state_d     = NEXT_ROW;
            end
          end else begin
            word_idx_d = word_idx_q + 17'd1;
            addr_d     = row_addr_q + ADDR_WIDTH'(word_idx_d);
            wben_d     = lane_mask(word_idx_d, n_words_q, lane_first_q, lane_last_q);
          end
        end
      end
      NEXT_ROW: begin
        word_idx_d = 17'd0;
        addr_d     = row_addr_q;
        wben_d     = lane_mask(17'd0, n_words_q, lane_first_q, lane_last_q);
        rts_d      = 1'b1;
        state_d    = ROW;
      end
      DONE: begin
        busy_d  = 1'b0;
        rtr_d   = 1'b1;
        state_d = COLLECT;
      end
      default: state_d = COLLECT;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_) begin
      state_q      <= COLLECT;
      byte_cnt_q   <= '0;
      cmd_q        <= '0;
      rtr_q        <= 1'b0;
      rts_q        <= 1'b0;
      data_q       <= '0;
      addr_q       <= '0;
      wben_q       <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      row_addr_q   <= '0;
      word_idx_q   <= '0;
      n_words_q    <= '0;
      rows_left_q  <= '0;
      lane_first_q <= '0;
      lane_last_q  <= '0;
    end else begin
      state_q      <= state_d;
      byte_cnt_q   <= byte_cnt_d;
      cmd_q        <= cmd_d;
      rtr_q        <= rtr_d;
      rts_q        <= rts_d;
      data_q       <= data_d;
      addr_q       <= addr_d;
      wben_q       <= wben_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      row_addr_q   <= row_addr_d;
      word_idx_q   <= word_idx_d;
      n_words_q    <= n_words_d;
      rows_left_q  <= rows_left_d;
      lane_first_q <= lane_first_d;
      lane_last_q  <= lane_last_d;
    end
  end

endmodule

// File: tb/tb_fill_rect_stream_engine.sv
// Testbench for fill_rect_stream_engine: drives fill commands, models the
// expected word writes at pixel level and checks every arbiter transfer.
module tb_fill_rect_stream_engine;

  localparam int AW = 16;
  localparam int LP = 256;
  localparam int SL = 192;
  localparam int FB = 0;

  logic          clk;
  logic          rst_;
  logic [7:0]    cmd_in_data;
  logic          cmd_in_rts;
  logic          cmd_out_rtr;
  logic [31:0]   arb_out_data;
  logic [AW-1:0] arb_out_addr;
  logic [3:0]    arb_out_wben;
  logic          arb_out_rts;
  logic          arb_in_rtr;
  logic          arb_out_op;
  logic          busy;
  logic          rect_done;

  fill_rect_stream_engine #(
    .ADDR_WIDTH(AW), .LINE_PIXELS(LP), .SCREEN_LINES(SL), .FB_BASE(FB)
  ) dut (
    .clk(clk), .rst_(rst_),
    .cmd_in_data(cmd_in_data), .cmd_in_rts(cmd_in_rts), .cmd_out_rtr(cmd_out_rtr),
    .arb_out_data(arb_out_data), .arb_out_addr(arb_out_addr), .arb_out_wben(arb_out_wben),
    .arb_out_rts(arb_out_rts), .arb_in_rtr(arb_in_rtr), .arb_out_op(arb_out_op),
    .busy(busy), .rect_done(rect_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [15:0] exp_addr[$];
  logic [3:0]  exp_wben[$];
  logic [15:0] obs_addr[$];
  logic [3:0]  obs_wben[$];

  // Pixel-level reference: walk every pixel of the rectangle, group by word.
  task automatic build_model(input int x, input int y, input int w, input int h);
    int ww, hh, word, prev;
    longint pix;
    exp_addr.delete();
    exp_wben.delete();
    ww = w;
    hh = h;
`ifdef FILL_RECT_CLIP_EN
    if (x >= LP || y >= SL) begin
      ww = 0;
      hh = 0;
    end else begin
      if (ww > LP - x) ww = LP - x;
      if (hh > SL - y) hh = SL - y;
    end
`endif
    for (int r = 0; r < hh; r++) begin
      prev = -1;
      for (int c = 0; c < ww; c++) begin
        pix  = longint'(y + r) * LP + x + c;
        word = int'((FB + (pix >> 2)) % 65536);
        if (word != prev) begin
          exp_addr.push_back(word[15:0]);
          exp_wben.push_back(4'b0000);
          prev = word;
        end
        exp_wben[exp_wben.size()-1] = exp_wben[exp_wben.size()-1] | (4'b0001 << (pix % 4));
      end
    end
  endtask

  // Sends the nine command bytes; returns right after the edge accepting byte 9.
  task automatic send_cmd(input int x, input int y, input int w, input int h, input logic [7:0] color);
    logic [7:0] b[9];
    int g;
    b[0] = x[7:0]; b[1] = x[15:8]; b[2] = y[7:0]; b[3] = y[15:8];
    b[4] = w[7:0]; b[5] = w[15:8]; b[6] = h[7:0]; b[7] = h[15:8]; b[8] = color;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      cmd_in_data = b[i];
      cmd_in_rts  = 1'b1;
      g = 0;
      while (cmd_out_rtr !== 1'b1 && g < 50) begin
        @(negedge clk);
        g++;
      end
      if (g >= 50) begin
        checks++;
        errors++;
        $display("[TB] FAIL cmd_accept_timeout byte=%0d rtr=%b required 1", i, cmd_out_rtr);
      end
      @(posedge clk);
    end
  endtask

  // Runs one rectangle: mode 0 always ready, 1 random ready, 2 stall word 1 for 3 cycles.
  // abort_at>0 returns at that cycle after byte 9 without finishing.
  task automatic run_rect(input int x, input int y, input int w, input int h,
                          input logic [7:0] color, input int mode, input int abort_at);
    int cyc, idx, last_acc, stall;
    bit done, r, pend;
    logic [15:0] pa;
    logic [3:0] pw;
    logic [31:0] pd, expd;
    build_model(x, y, w, h);
    obs_addr.delete();
    obs_wben.delete();
    expd = {color, color, color, color};
    send_cmd(x, y, w, h, color);
    cyc = 0; idx = 0; last_acc = -1; stall = 3; done = 0; pend = 0;
    pa = '0; pw = '0; pd = '0;
    while (!done && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      cmd_in_rts = 1'b0;
      if (abort_at != 0 && cyc == abort_at) begin
        arb_in_rtr = 1'b0;
        return;
      end
      if (cyc == 1) begin
        checks++;
        if (arb_out_rts !== 1'b0) begin
          errors++;
          $display("[TB] FAIL setup_rts got %b required 0", arb_out_rts);
        end
      end
      if (cyc == 2) begin
        checks++;
        if (exp_addr.size() == 0 && rect_done !== 1'b1) begin
          errors++;
          $display("[TB] FAIL empty_done_latency rect_done=%b required 1", rect_done);
        end else if (exp_addr.size() != 0 && arb_out_rts !== 1'b1) begin
          errors++;
          $display("[TB] FAIL first_rts_latency rts=%b required 1", arb_out_rts);
        end
      end
      if (pend) begin
        checks++;
        if (arb_out_rts !== 1'b1 || arb_out_addr !== pa || arb_out_wben !== pw || arb_out_data !== pd) begin
          errors++;
          $display("[TB] FAIL stall_hold rts=%b addr=%h wben=%h data=%h required 1 %h %h %h",
                   arb_out_rts, arb_out_addr, arb_out_wben, arb_out_data, pa, pw, pd);
        end
      end
      if (rect_done === 1'b1) begin
        done = 1;
        checks++;
        if (idx != exp_addr.size() || busy !== 1'b1 || arb_out_rts !== 1'b0) begin
          errors++;
          $display("[TB] FAIL done_state writes=%0d busy=%b rts=%b required %0d 1 0",
                   idx, busy, arb_out_rts, exp_addr.size());
        end
        if (idx > 0) begin
          checks++;
          if (last_acc != cyc - 1) begin
            errors++;
            $display("[TB] FAIL done_timing done_cycle=%0d required %0d", cyc, last_acc + 1);
          end
        end
      end
      case (mode)
        1: r = ($urandom_range(0, 3) != 0);
        2: begin
          r = 1;
          if (arb_out_rts === 1'b1 && idx == 1 && stall > 0) begin
            r = 0;
            stall--;
          end
        end
        default: r = 1;
      endcase
      arb_in_rtr = r;
      if (arb_out_rts === 1'b1 && r) begin
        obs_addr.push_back(arb_out_addr);
        obs_wben.push_back(arb_out_wben);
        checks++;
        if (idx >= exp_addr.size()) begin
          errors++;
          $display("[TB] FAIL extra_write addr=%h wben=%h required none", arb_out_addr, arb_out_wben);
        end else if (arb_out_addr !== exp_addr[idx] || arb_out_wben !== exp_wben[idx] || arb_out_data !== expd) begin
          errors++;
          $display("[TB] FAIL write%0d addr=%h wben=%h data=%h required %h %h %h", idx,
                   arb_out_addr, arb_out_wben, arb_out_data, exp_addr[idx], exp_wben[idx], expd);
        end
        idx++;
        last_acc = cyc;
      end
      pend = (arb_out_rts === 1'b1) && !r;
      pa = arb_out_addr; pw = arb_out_wben; pd = arb_out_data;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("[TB] FAIL done_timeout rect_done=%b required 1", rect_done);
    end
    @(negedge clk);
    arb_in_rtr = 1'b0;
    checks++;
    if (rect_done !== 1'b0 || busy !== 1'b0 || cmd_out_rtr !== 1'b1 || arb_out_rts !== 1'b0) begin
      errors++;
      $display("[TB] FAIL after_done done=%b busy=%b rtr=%b rts=%b required 0 0 1 0",
               rect_done, busy, cmd_out_rtr, arb_out_rts);
    end
  endtask

  task automatic test_reset();
    rst_ = 1'b0; cmd_in_rts = 1'b0; cmd_in_data = '0; arb_in_rtr = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (cmd_out_rtr !== 1'b0 || arb_out_rts !== 1'b0 || arb_out_data !== 32'h0 || arb_out_addr !== 16'h0 ||
        arb_out_wben !== 4'h0 || busy !== 1'b0 || rect_done !== 1'b0 || arb_out_op !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_outputs rtr=%b rts=%b data=%h addr=%h wben=%h busy=%b done=%b op=%b required 0 0 0 0 0 0 0 1",
               cmd_out_rtr, arb_out_rts, arb_out_data, arb_out_addr, arb_out_wben, busy, rect_done, arb_out_op);
    end
    rst_ = 1'b1;
    @(negedge clk);
    checks++;
    if (cmd_out_rtr !== 1'b1) begin
      errors++;
      $display("[TB] FAIL rtr_after_reset got %b required 1", cmd_out_rtr);
    end
  endtask

  task automatic test_single_word();
    run_rect(0, 0, 4, 1, 8'hA5, 0, 0);
    checks++;
    if (obs_addr.size() != 1 || obs_addr[0] !== 16'h0000 || obs_wben[0] !== 4'hF) begin
      errors++;
      $display("[TB] FAIL single_word count=%0d required 1 addr 0000 wben f", obs_addr.size());
    end
  endtask

  task automatic test_two_words();
    run_rect(2, 1, 5, 1, 8'h3C, 0, 0);
    checks++;
    if (obs_addr.size() != 2 || obs_addr[0] !== 16'h0040 || obs_wben[0] !== 4'hC ||
        obs_addr[1] !== 16'h0041 || obs_wben[1] !== 4'h7) begin
      errors++;
      $display("[TB] FAIL two_words count=%0d required 0040/c 0041/7", obs_addr.size());
    end
  endtask

  task automatic test_stall();
    run_rect(0, 0, 8, 2, 8'h5A, 2, 0);
    checks++;
    if (obs_addr.size() != 4 || obs_addr[0] !== 16'h0000 || obs_addr[1] !== 16'h0001 ||
        obs_addr[2] !== 16'h0040 || obs_addr[3] !== 16'h0041) begin
      errors++;
      $display("[TB] FAIL stall_sequence count=%0d required 0000 0001 0040 0041", obs_addr.size());
    end
  endtask

  task automatic test_empty();
    run_rect(5, 5, 0, 3, 8'h11, 0, 0);
    checks++;
    if (obs_addr.size() != 0) begin
      errors++;
      $display("[TB] FAIL empty_writes count=%0d required 0", obs_addr.size());
    end
  endtask

  task automatic test_edge();
    run_rect(254, 191, 10, 5, 8'hE7, 1, 0);
    checks++;
`ifdef FILL_RECT_CLIP_EN
    if (obs_addr.size() != 1 || obs_addr[0] !== 16'h2FFF || obs_wben[0] !== 4'hC) begin
      errors++;
      $display("[TB] FAIL edge_clip count=%0d required 1 write 2fff/c", obs_addr.size());
    end
`else
    if (obs_addr.size() != 15 || obs_addr[0] !== 16'h2FFF || obs_wben[0] !== 4'hC ||
        obs_addr[14] !== 16'h3101 || obs_wben[14] !== 4'hF) begin
      errors++;
      $display("[TB] FAIL edge_noclip count=%0d required 15 first 2fff/c last 3101/f", obs_addr.size());
    end
`endif
  endtask

  task automatic test_mid_reset();
    run_rect(10, 5, 12, 4, 8'h77, 0, 8);
    rst_ = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (arb_out_rts !== 1'b0 || busy !== 1'b0 || cmd_out_rtr !== 1'b0 || arb_out_addr !== 16'h0) begin
      errors++;
      $display("[TB] FAIL mid_reset rts=%b busy=%b rtr=%b addr=%h required 0 0 0 0",
               arb_out_rts, busy, cmd_out_rtr, arb_out_addr);
    end
    rst_ = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (arb_out_rts !== 1'b0 || cmd_out_rtr !== 1'b1) begin
        errors++;
        $display("[TB] FAIL post_reset_idle rts=%b rtr=%b required 0 1", arb_out_rts, cmd_out_rtr);
      end
    end
    run_rect(3, 7, 9, 2, 8'h42, 1, 0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 20; n++) begin
      run_rect(int'($urandom_range(0, 299)), int'($urandom_range(0, 199)), int'($urandom_range(0, 20)),
               int'($urandom_range(0, 4)), 8'($urandom), 1, 0);
    end
  endtask

  task automatic test_back_to_back();
    run_rect(1, 0, 3, 1, 8'h01, 0, 0);
    run_rect(6, 2, 7, 3, 8'h02, 0, 0);
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_two_words();
    test_stall();
    test_empty();
    test_edge();
    test_mid_reset();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
